// File: rtl/vector_pkg.sv
// vector_pkg: shared fp16 vector types, vexp sequencer states and the flush-to-zero helper.
package vector_pkg;
   typedef logic [15:0] fp16_t;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} vexp_seq_state_t;
   localparam int VEXP_SEQ_MAX_LAT = 8;
   function automatic fp16_t ftz(input fp16_t x);
      return (x[14:10] == 5'd0 && x[9:0] != 10'd0) ? {x[15], 15'd0} : x;
   endfunction
endpackage

// File: rtl/vexp_lat_pipe.sv
// vexp_lat_pipe: DEPTH-deep valid-tag shift register with async clear; DEPTH=0 is a wire.
module vexp_lat_pipe #(
   parameter int DEPTH = 2
) (
   input  logic CLK,
   input  logic nRST,
   input  logic tag_in,
   output logic tag_out
);
   if (DEPTH == 0) begin : g_wire
      logic unused;
      assign unused = CLK ^ nRST;
      assign tag_out = tag_in;
   end else begin : g_sr
      logic [DEPTH-1:0] sr;
      always_ff @(posedge CLK or negedge nRST)
         if (!nRST) sr <= '0;
         else sr <= DEPTH'({sr, tag_in});
      assign tag_out = sr[DEPTH-1];
   end
endmodule

// File: rtl/vexp_seq.sv
// vexp_seq: serialises a fp16 vector through one scalar vexp unit and reassembles the results.
// Define VEXP_SEQ_FTZ_EN to issue subnormal operands as sign-preserving zeros.
module vexp_seq
   import vector_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int EXP_LAT   = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_LANES*16-1:0] in_vec,
   output logic [15:0]            exp_port_a,
   output logic                   exp_enable,
   input  logic [15:0]            exp_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_LANES*16-1:0] out_vec,
   output logic                   busy
);
   localparam int CW  = $clog2(NUM_LANES + 1);
   localparam int LAT = (EXP_LAT > VEXP_SEQ_MAX_LAT) ? VEXP_SEQ_MAX_LAT : EXP_LAT;
   localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_LANES);

   vexp_seq_state_t state, state_nx;
   fp16_t op [NUM_LANES];
   fp16_t res [NUM_LANES];
   logic [CW-1:0] issue_cnt, cap_cnt;
   logic tag_out, cap_done;
   fp16_t lane, issue_op;

   vexp_lat_pipe #(.DEPTH(LAT)) u_pipe (.CLK, .nRST, .tag_in(exp_enable), .tag_out);

   always_comb begin
      lane = '0;
      for (int i = 0; i < NUM_LANES; i++) if (issue_cnt == CW'(i)) lane = op[i];
   end

`ifdef VEXP_SEQ_FTZ_EN
   assign issue_op = ftz(lane);
`else
   assign issue_op = lane;
`endif

   // counts the capture landing this cycle so DONE is reached without a dead cycle
   assign cap_done = (cap_cnt + CW'(tag_out)) == FULL;
   assign busy = state != IDLE;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_out
      assign out_vec[16*k +: 16] = res[k];
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      exp_enable = 1'b0;
      exp_port_a = '0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ISSUE;
         end
         ISSUE: begin
            exp_enable = 1'b1;
            exp_port_a = issue_op;
            if (issue_cnt == LAST) state_nx = cap_done ? DONE : DRAIN;
         end
         DRAIN: state_nx = cap_done ? DONE : DRAIN;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         issue_cnt <= '0;
         cap_cnt <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            op[i] <= '0;
            res[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (in_ready && in_valid) begin
            issue_cnt <= '0;
            cap_cnt <= '0;
            for (int i = 0; i < NUM_LANES; i++) op[i] <= in_vec[16*i +: 16];
         end else begin
            if (exp_enable && issue_cnt != FULL) issue_cnt <= issue_cnt + CW'(1);
            if (tag_out && cap_cnt != FULL) begin
               cap_cnt <= cap_cnt + CW'(1);
               for (int i = 0; i < NUM_LANES; i++) if (cap_cnt == CW'(i)) res[i] <= exp_out;
            end
         end
      end
   end
endmodule
